// File: rtl/ascon_dec_stream_ctrl.sv
// Stream front/back end for ascon128_decrypt: packs a 64-byte frame into the
// core's key/nonce/ciphertext/tag, runs the core with a bounded wait, and
// returns plaintext only when the tag authenticates.
`timescale 1ns/1ps
module ascon_dec_stream_ctrl #(
  parameter int DONE_TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] core_key,
  output logic [127:0] core_nonce,
  output logic [127:0] core_ciphertext,
  output logic [127:0] core_tag,
  output logic         core_start,
  input  logic [127:0] core_plaintext,
  input  logic         core_tag_valid,
  input  logic         core_done,
  output logic [127:0] out_plaintext,
  output logic [1:0]   out_err,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic [2:0] {LOAD, DRAIN, ARM, RUN, RESULT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);
  localparam logic [1:0] E_OK = 2'd0, E_AUTH = 2'd1, E_FRAME = 2'd2, E_TMO = 2'd3;

  state_t              state, state_n;
  logic [5:0]          idx;
  logic [7:0]          cyc;
  logic [3:0][15:0][7:0] fld;   // fld[field][byte], byte 15 is the MSB lane
  logic                accept;
  logic                res_ld;
  logic [1:0]          res_err;
  logic [127:0]        res_pt;

  assign accept          = in_valid && in_ready;
  assign core_key        = fld[0];
  assign core_nonce      = fld[1];
  assign core_ciphertext = fld[2];
  assign core_tag        = fld[3];
  assign core_start      = (state == RUN);
  assign out_valid       = (state == RESULT);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else        state <= state_n;

  // Next state and result selection; non-zero errors always carry zero plaintext
  always_comb begin
    state_n = state;
    res_ld  = 1'b0;
    res_err = E_OK;
    res_pt  = '0;
    case (state)
      LOAD:
        if (accept) begin
          if (idx == 6'd63)  state_n = in_last ? ARM : DRAIN;
          else if (in_last) begin
            state_n = RESULT;
            res_ld  = 1'b1;
            res_err = E_FRAME;
          end
        end
      DRAIN:
        if (accept && in_last) begin
          state_n = RESULT;
          res_ld  = 1'b1;
          res_err = E_FRAME;
        end
      ARM: state_n = RUN;
      RUN:
        if (core_done) begin
          state_n = RESULT;
          res_ld  = 1'b1;
          if (core_tag_valid) begin
            res_err = E_OK;
            res_pt  = core_plaintext;
          end else begin
            res_err = E_AUTH;
          end
        end else if (cyc == TMO_LAST) begin
          state_n = RESULT;
          res_ld  = 1'b1;
          res_err = E_TMO;
        end
      RESULT: if (out_ready) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises one clock after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= (state_n == LOAD) || (state_n == DRAIN);

  // Byte index: advances on frame bytes only, cleared once the result is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          idx <= '0;
    else if (state == RESULT && out_ready) idx <= '0;
    else if (state == LOAD && accept)    idx <= idx + 6'd1;

  // Field capture, big-endian within each 16-byte field
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       fld <= '0;
    else if (state == LOAD && accept) fld[idx[5:4]][~idx[3:0]] <= in_data;

  // RUN cycle counter, zeroed in ARM so it reads 0 on the first RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              cyc <= '0;
    else if (state == ARM)   cyc <= '0;
    else if (state == RUN)   cyc <= cyc + 8'd1;

  // Result register: loaded on the transition into RESULT, cleared once consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_plaintext <= '0;
      out_err       <= '0;
    end else if (res_ld) begin
      out_plaintext <= res_pt;
      out_err       <= res_err;
    end else if (state == RESULT && out_ready) begin
      out_plaintext <= '0;
      out_err       <= '0;
    end
endmodule
